// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: opcodes, the NOP word and instruction field positions.
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_LW    = 6'h23;
    localparam logic [5:0]  OP_SW    = 6'h2B;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Only these formats read rt as a source; I-type ALU ops and loads write it instead.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/if_id_pipe_hazard_detect.sv
// Load-use hazard detection for the instruction sitting in ID; purely combinational.
module hazard_detect
    import mips_pkg::*;
(
    input  logic       i_valid,
    input  logic [5:0] i_opcode,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_idex_mem_read,
    input  logic [4:0] i_idex_rt,
    input  logic       i_flush,
    output logic       o_hazard,
    output logic       o_stall,
    output logic       o_pc_write,
    output logic       o_bubble
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_idex_rt == i_rs);
    assign w_rt_match = uses_rt(i_opcode) && (i_idex_rt == i_rt);

    assign o_hazard   = i_valid && i_idex_mem_read && (i_idex_rt != 5'd0)
                        && (w_rs_match || w_rt_match);
    // A flush overrides the stall so the branch target still reaches the PC.
    assign o_stall    = o_hazard && !i_flush;
    assign o_pc_write = !o_stall;
    assign o_bubble   = o_hazard || i_flush;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with load-use stall, branch flush and saturating perf counters.
module if_id_pipe
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_WORD,
    parameter int          CNT_W     = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      PC_in,
    input  logic [31:0]      instr_in,
    input  logic             flush,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    output logic [31:0]      PC_pass,
    output logic [31:0]      instr_out,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [15:0]      imm,
    output logic             valid,
    output logic             pc_write,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0]      r_instr;
    logic [31:0]      r_pc;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_hazard;
    logic             w_stall;

    hazard_detect u_hazard (
        .i_valid        (r_valid),
        .i_opcode       (opcode),
        .i_rs           (rs),
        .i_rt           (rt),
        .i_idex_mem_read(idex_mem_read),
        .i_idex_rt      (idex_rt),
        .i_flush        (flush),
        .o_hazard       (w_hazard),
        .o_stall        (w_stall),
        .o_pc_write     (pc_write),
        .o_bubble       (bubble)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr     <= NOP_INSTR;
            r_pc        <= 32'd0;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (flush) begin
            r_instr <= NOP_INSTR;
            r_pc    <= 32'd0;
            r_valid <= 1'b0;
            if (r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end else if (w_stall) begin
            if (r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_instr <= instr_in;
            r_pc    <= PC_in;
            r_valid <= 1'b1;
        end
    end

    assign PC_pass   = r_pc;
    assign instr_out = r_instr;
    assign valid     = r_valid;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    assign opcode = r_instr[OPCODE_MSB:OPCODE_LSB];
    assign rs     = r_instr[RS_MSB:RS_LSB];
    assign rt     = r_instr[RT_MSB:RT_LSB];
    assign rd     = r_instr[RD_MSB:RD_LSB];
    assign imm    = r_instr[IMM_MSB:IMM_LSB];

endmodule
